// File: rtl/mc_sequencer_pkg.sv
// Shared definitions for the multi-cycle sequencer: FSM state encoding and
// the RV32I base opcode constants also used by the decoder.
package mc_sequencer_pkg;

  typedef enum logic [2:0] {
    MC_S_HALT   = 3'd0,
    MC_S_FETCH  = 3'd1,
    MC_S_DECODE = 3'd2,
    MC_S_EXEC   = 3'd3,
    MC_S_MEM    = 3'd4,
    MC_S_WB     = 3'd5,
    MC_S_ERR    = 3'd6
  } mc_state_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  function automatic logic is_rv32i_opcode(input logic [6:0] opc);
    case (opc)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
      OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP: return 1'b1;
      default:                                 return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_perf_cnt.sv
// Free-running active-cycle and retired-instruction counters for the
// sequencer; both wrap modulo 2^32.
module mc_perf_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        count_en,
  input  logic        retire,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt   <= 32'd0;
      instret_cnt <= 32'd0;
    end else begin
      if (count_en) cycle_cnt   <= cycle_cnt + 32'd1;
      if (retire)   instret_cnt <= instret_cnt + 32'd1;
    end
  end

endmodule

// File: rtl/mc_sequencer.sv
// Multi-cycle RV32I sequencer: FETCH/DECODE/EXEC/MEM/WB over one shared memory
// port. Define MC_PERF_CNT_EN to add the cycle_cnt/instret_cnt counters.
module mc_sequencer
  import mc_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [6:0]  opcode,
  input  logic        dec_pc_sel,
  input  logic        dec_reg_wen,
  input  logic        dec_mem_rw,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        addr_sel,
  output logic        ir_we,
  output logic        mdr_we,
  output logic        pc_we,
  output logic        pc_sel,
  output logic        reg_we,
  output logic        retire,
  output logic        halted,
  output logic        illegal
`ifdef MC_PERF_CNT_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
`endif
);

  mc_state_e state, state_d;
  mc_state_e boundary_d;
  logic      is_load, is_store, is_branch;
  logic      commit;

  assign is_load    = (opcode == OPC_LOAD);
  assign is_store   = (opcode == OPC_STORE);
  assign is_branch  = (opcode == OPC_BRANCH);
  // run only matters at the retire cycle; mid-instruction changes are ignored.
  assign boundary_d = run ? MC_S_FETCH : MC_S_HALT;

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state;
    case (state)
      MC_S_HALT:   if (run) state_d = MC_S_FETCH;
      MC_S_FETCH:  if (mem_ready) state_d = MC_S_DECODE;
      MC_S_DECODE: state_d = is_rv32i_opcode(opcode) ? MC_S_EXEC : MC_S_ERR;
      MC_S_EXEC: begin
        if (is_load || is_store) state_d = MC_S_MEM;
        else if (is_branch)      state_d = boundary_d;
        else                     state_d = MC_S_WB;
      end
      MC_S_MEM:    if (mem_ready) state_d = is_store ? boundary_d : MC_S_WB;
      MC_S_WB:     state_d = boundary_d;
      MC_S_ERR:    state_d = MC_S_ERR;
      default:     state_d = MC_S_HALT;
    endcase
  end

  // Phase-gated enables; commit marks the retire cycle of every instruction.
  always_comb begin
    ir_we  = 1'b0;
    mdr_we = 1'b0;
    reg_we = 1'b0;
    commit = 1'b0;
    case (state)
      MC_S_FETCH: ir_we = mem_ready;
      MC_S_EXEC:  commit = is_branch;
      MC_S_MEM: begin
        if (mem_ready) begin
          if (is_store) commit = 1'b1;
          else          mdr_we = 1'b1;
        end
      end
      MC_S_WB: begin
        commit = 1'b1;
        reg_we = dec_reg_wen;
      end
      default: ;
    endcase
  end

  assign pc_we  = commit;
  assign retire = commit;
  assign pc_sel = commit & dec_pc_sel;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= MC_S_HALT;
      mem_req  <= 1'b0;
      mem_we   <= 1'b0;
      addr_sel <= 1'b0;
      halted   <= 1'b1;
      illegal  <= 1'b0;
    end else begin
      state    <= state_d;
      mem_req  <= (state_d == MC_S_FETCH) || (state_d == MC_S_MEM);
      addr_sel <= (state_d == MC_S_FETCH);
      // Direction is captured on MEM entry and held until mem_ready.
      mem_we   <= (state_d == MC_S_MEM) && ((state == MC_S_MEM) ? mem_we : dec_mem_rw);
      halted   <= (state_d == MC_S_HALT);
      illegal  <= (state_d == MC_S_ERR);
    end
  end

`ifdef MC_PERF_CNT_EN
  logic active;
  assign active = (state != MC_S_HALT) && (state != MC_S_ERR);

  mc_perf_cnt u_perf_cnt (
    .clk         (clk),
    .rst         (rst),
    .count_en    (active),
    .retire      (commit),
    .cycle_cnt   (cycle_cnt),
    .instret_cnt (instret_cnt)
  );
`endif

endmodule

// File: doc/mc_sequencer.md
# mc_sequencer

Multi-cycle sequencer for the RV32I core. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB over one shared instruction/data memory port. It gates the combinational decoder's register-write, memory-write and PC-select decisions so they take effect only in the correct phase. It sits between the decoder and the PC, IR, MDR, register-file and memory-port enables.

## Interface
- No parameters. Widths are fixed by RV32I.
- clk  in  1  core clock
- rst  in  1  reset; asynchronous, active-high (already decided)
- run  in  1  level; 1 = keep issuing instructions, 0 = halt at the next instruction boundary
- opcode  in  7  IR[6:0]
- dec_pc_sel  in  1  decoder PC select (already includes brtaken)
- dec_reg_wen  in  1  decoder register-write request
- dec_mem_rw  in  1  decoder memory direction (1 = write)
- mem_ready  in  1  memory completes the current request this cycle
- mem_req  out  1  memory request
- mem_we  out  1  memory write strobe, qualified by mem_req
- addr_sel  out  1  memory address source: 1 = PC, 0 = ALU result
- ir_we  out  1  IR load
- mdr_we  out  1  MDR load
- pc_we  out  1  PC update
- pc_sel  out  1  PC source, forwarded from dec_pc_sel when pc_we=1, else 0
- reg_we  out  1  register-file write
- retire  out  1  one-cycle pulse when an instruction completes
- halted  out  1  1 while in HALT
- illegal  out  1  sticky illegal-opcode flag
- cycle_cnt, instret_cnt  out  32 each  present only with MC_PERF_CNT_EN

## Operation
- States: HALT, FETCH, DECODE, EXEC, MEM, WB, ERR. Reset state is HALT.
- HALT: halted=1. Go to FETCH when run=1.
- FETCH: mem_req=1, addr_sel=1, mem_we=0. Wait while mem_ready=0. When mem_ready=1: ir_we=1, go to DECODE.
- DECODE: one cycle. Opcode outside the nine RV32I base opcodes (LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP) goes to ERR. Any other opcode goes to EXEC.
- EXEC: one cycle.
  - LOAD/STORE go to MEM.
  - BRANCH: pc_we=1, pc_sel=dec_pc_sel, retire=1, then go to FETCH if run=1, else HALT.
  - All other opcodes go to WB.
- MEM: mem_req=1, addr_sel=0, mem_we=dec_mem_rw. Hold while mem_ready=0.
  - Store completes on mem_ready: pc_we=1, retire=1, then go to FETCH/HALT per run.
  - Load completes on mem_ready: mdr_we=1, go to WB.
- WB: reg_we=dec_reg_wen, pc_we=1, pc_sel=dec_pc_sel, retire=1, then go to FETCH/HALT per run.
- ERR: illegal=1, every enable 0. Only rst exits ERR.
- Output decoding:
  - mem_req, mem_we, addr_sel, halted and illegal depend on state only.
  - ir_we, mdr_we, pc_we and retire in FETCH/MEM are additionally gated by mem_ready.
- run is sampled only at instruction boundaries (the retire cycle) and in HALT. Deasserting run mid-instruction lets that instruction finish.

## Timing
- Reset values: every output 0 except halted=1. State=HALT. Counters=0.
- Latency with zero-wait memory (mem_ready in the request cycle): BRANCH 3 cycles, ALU/LUI/AUIPC/JAL/JALR 4, STORE 4, LOAD 5. Each memory wait cycle adds one.
- mem_req stays asserted and stable, with addr_sel and mem_we unchanged, until mem_ready.
- Back-to-back instructions: FETCH follows the retire cycle directly, with no bubble.
- rst asserted mid-transfer drops mem_req immediately. The memory side must tolerate an abandoned request.
- mem_ready outside FETCH/MEM is ignored.

## Configuration
- MC_PERF_CNT_EN defined:
  - cycle_cnt increments every cycle not in HALT or ERR.
  - instret_cnt increments on retire.
  - Both are 32-bit, wrap modulo 2^32, and are cleared by rst.
- Undefined: both ports and all counter logic are absent. Sequencing is identical.

## Structure
- The shared core macro header holds:
  - the state encodings (3-bit: MC_S_HALT=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, ERR=6);
  - the RV32I opcode constants, shared with the decoder rather than redefined locally.
- One sub-module, mc_perf_cnt, holds the two counters. It is instantiated only under MC_PERF_CNT_EN.

## Test plan
- Reset, run=1, ADDI (0x13) with mem_ready tied 1 → states HALT, FETCH, DECODE, EXEC, WB. reg_we=1 and retire=1 in the WB cycle. instret_cnt=1.
- LW (0x03) with 2 wait cycles in MEM → mem_req held 3 cycles with addr_sel=0, mem_we=0. Then mdr_we=1, then WB. LOAD total 7 cycles.
- SW (0x23) → mem_we=1 in MEM, reg_we never 1, retire on the mem_ready cycle.
- BEQ with dec_pc_sel=1 → pc_we=1 and pc_sel=1 in EXEC, no WB, next state FETCH.
- Opcode 0x7F → ERR after DECODE, illegal=1 held across 10 cycles, all enables 0. Then rst → HALT with illegal=0.
- run dropped during EXEC of an ALU op → WB completes with retire=1, then HALT with halted=1. rst asserted during a waiting FETCH → mem_req falls asynchronously.
